seg_display_ctrl: RTL and testbench

Parametrised seven-segment output stage sitting between the calendar/clock/D-day formatters and the board HEX pins. It selects one of `SRCS` pre-encoded display frames and applies a per-digit blink mask from an internal, restartable blink timer. It also applies a per-digit blank mask and drives registered segment outputs. It generalises the fixed 8-digit, 4-source output stage with an external 4 Hz blink clock into a single-clock block with any digit count and source count. It adds blink-restart-on-edit and glitch-free registered outputs.

---
 rtl/seg_pkg.sv | 20 ++
 rtl/blink_timer.sv | 40 ++++
 rtl/seg_display_ctrl.sv | 88 ++++++++
 tb/tb_seg_display_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
//------------------------------------------------------------------------------
// seg_pkg : shared seven-segment widths, OFF encodings and polarity helper.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package seg_pkg;

  localparam int              SEG_W      = 7;
  localparam logic [SEG_W-1:0] SEG_OFF_AL = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_OFF_AH = 7'h00;

  function automatic logic [SEG_W-1:0] seg_off(input logic active_low);
    return active_low ? SEG_OFF_AL : SEG_OFF_AH;
  endfunction

endpackage

`default_nettype wire

// File: rtl/blink_timer.sv
//------------------------------------------------------------------------------
// blink_timer : restartable half-period counter producing the blink phase.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module blink_timer #(
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic restart,
  output logic phase
);

  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // Restart outranks the terminal-count toggle so an edit always starts visible.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      phase <= 1'b0;
    end else if (restart) begin
      r_cnt <= '0;
      phase <= 1'b0;
    end else if (r_cnt == c_cnt_last) begin
      r_cnt <= '0;
      phase <= ~phase;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/seg_display_ctrl.sv
//------------------------------------------------------------------------------
// seg_display_ctrl : frame select, blink/blank masking, registered HEX outputs.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS     = 8,
  parameter int SRCS       = 4,
  parameter int SEL_W      = (SRCS > 1) ? $clog2(SRCS) : 1,
  parameter int BLINK_DIV  = 12_500_000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [SRCS*DIGITS*SEG_W-1:0] src_data,
  input  logic [SEL_W-1:0]             src_sel,
  input  logic [DIGITS-1:0]            blink_mask,
  input  logic [DIGITS-1:0]            blank_mask,
  input  logic                         blink_en,
  output logic [DIGITS*SEG_W-1:0]      hex,
  output logic                         blink_phase
);

  localparam int               c_frame_w = DIGITS * SEG_W;
  localparam logic [SEG_W-1:0] c_off     = seg_off(ACTIVE_LOW != 0);

  logic [DIGITS-1:0]    r_blink_mask_q;
  logic [SEL_W-1:0]     r_src_sel_q;
  logic                 w_restart;
  logic [c_frame_w-1:0] w_frame;
  logic                 w_sel_ok;
  logic [c_frame_w-1:0] w_hex_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_mask_q <= '0;
      r_src_sel_q    <= '0;
    end else begin
      r_blink_mask_q <= blink_mask;
      r_src_sel_q    <= src_sel;
    end
  end

  assign w_restart = (blink_mask != r_blink_mask_q) ||
                     (src_sel != r_src_sel_q) || !blink_en;

  blink_timer #(
    .BLINK_DIV (BLINK_DIV)
  ) u_blink_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .restart (w_restart),
    .phase   (blink_phase)
  );

  // A select with no matching frame leaves w_sel_ok low, which blanks the display.
  always_comb begin
    w_frame  = '0;
    w_sel_ok = 1'b0;
    for (int s = 0; s < SRCS; s++) begin
      if (src_sel == SEL_W'(s)) begin
        w_frame  = src_data[s*c_frame_w +: c_frame_w];
        w_sel_ok = 1'b1;
      end
    end
  end

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    assign w_hex_next[d*SEG_W +: SEG_W] =
      (blank_mask[d] || (blink_mask[d] && blink_phase) || !w_sel_ok)
        ? c_off : w_frame[d*SEG_W +: SEG_W];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hex <= {DIGITS{c_off}};
    end else begin
      hex <= w_hex_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_display_ctrl.sv
//------------------------------------------------------------------------------
// tb_seg_display_ctrl : directed checks of select, blink, restart and blanking.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_seg_display_ctrl;

  localparam int HW = 56;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [4*HW-1:0] src_data;
  logic [1:0]    src_sel;
  logic [7:0]    blink_mask, blank_mask;
  logic          blink_en;
  logic [HW-1:0] hex;
  logic          blink_phase;

  logic [3*HW-1:0] src_data3;
  logic [1:0]    src_sel3;
  logic [7:0]    blink_mask3, blank_mask3;
  logic          blink_en3;
  logic [HW-1:0] hex3;
  logic          blink_phase3;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  seg_display_ctrl #(
    .DIGITS(8), .SRCS(4), .BLINK_DIV(4), .ACTIVE_LOW(1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .src_data(src_data), .src_sel(src_sel),
    .blink_mask(blink_mask), .blank_mask(blank_mask), .blink_en(blink_en),
    .hex(hex), .blink_phase(blink_phase)
  );

  seg_display_ctrl #(
    .DIGITS(8), .SRCS(3), .BLINK_DIV(1), .ACTIVE_LOW(0)
  ) dut3 (
    .clock(clock), .reset_n(reset_n), .src_data(src_data3), .src_sel(src_sel3),
    .blink_mask(blink_mask3), .blank_mask(blank_mask3), .blink_en(blink_en3),
    .hex(hex3), .blink_phase(blink_phase3)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [6:0] fdig(input int s, input int d);
    return 7'((s << 5) | d);
  endfunction

  function automatic logic [HW-1:0] exp_hex(input int sel, input logic [7:0] blk,
                                            input logic [7:0] bln, input bit ph,
                                            input bit al, input int srcs);
    logic [HW-1:0] v;
    logic [6:0]    off;
    off = al ? 7'h7F : 7'h00;
    for (int d = 0; d < 8; d++) begin
      if (bln[d] || (blk[d] && ph) || sel >= srcs) v[d*7 +: 7] = off;
      else                                         v[d*7 +: 7] = fdig(sel, d);
    end
    return v;
  endfunction

  initial begin
    reset_n     = 1'b0;
    src_sel     = 2'd0; blink_mask  = 8'h00; blank_mask  = 8'h00; blink_en  = 1'b1;
    src_sel3    = 2'd0; blink_mask3 = 8'h00; blank_mask3 = 8'h00; blink_en3 = 1'b1;
    for (int s = 0; s < 4; s++)
      for (int d = 0; d < 8; d++) src_data[s*HW + d*7 +: 7] = fdig(s, d);
    for (int s = 0; s < 3; s++)
      for (int d = 0; d < 8; d++) src_data3[s*HW + d*7 +: 7] = fdig(s, d);

    #12;
    check("rst_hex", hex, 56'hFF_FFFF_FFFF_FFFF);
    check("rst_phase", blink_phase, 0);
    check("rst_hex_ah", hex3, 56'h0);

    reset_n = 1'b1;
    src_sel = 2'd2;
    step();
    check("sel2_d0", hex[6:0], 7'h40);
    check("sel2_all", hex, exp_hex(2, 8'h00, 8'h00, 0, 1, 4));
    src_sel = 2'd1;
    step();
    check("sel1_all", hex, exp_hex(1, 8'h00, 8'h00, 0, 1, 4));

    // Blink: restart edge then a 4-cycle half period; hex lags phase by one edge.
    blink_mask = 8'h03;
    step();
    check("blk_ph_0", blink_phase, 0);
    check("blk_hex_0", hex, exp_hex(1, 8'h03, 8'h00, 0, 1, 4));
    for (int i = 1; i <= 12; i++) begin
      step();
      check($sformatf("blk_ph_%0d", i), blink_phase, 64'((i / 4) % 2));
      check($sformatf("blk_hex_%0d", i), hex,
            exp_hex(1, 8'h03, 8'h00, bit'(((i - 1) / 4) % 2), 1, 4));
    end
    step();
    check("blk_ph_13", blink_phase, 1);

    // Restart on mask edit while dark.
    blink_mask = 8'h0C;
    step();
    check("rs_ph", blink_phase, 0);
    check("rs_hex", hex, exp_hex(1, 8'h0C, 8'h00, 1, 1, 4));
    for (int j = 1; j <= 4; j++) begin
      step();
      check($sformatf("rs_ph_%0d", j), blink_phase, (j == 4) ? 64'd1 : 64'd0);
      check($sformatf("rs_hex_%0d", j), hex, exp_hex(1, 8'h0C, 8'h00, 0, 1, 4));
    end

    // Restart priority: select change lands on the terminal-count edge.
    src_sel = 2'd0;
    step();
    check("pr_ph_0", blink_phase, 0);
    for (int j = 1; j <= 3; j++) step();
    check("pr_ph_3", blink_phase, 0);
    src_sel = 2'd3;
    step();
    check("pr_ph_tc", blink_phase, 0);
    check("pr_hex", hex, exp_hex(3, 8'h0C, 8'h00, 0, 1, 4));
    for (int j = 5; j <= 7; j++) step();
    check("pr_ph_7", blink_phase, 0);
    step();
    check("pr_ph_8", blink_phase, 1);

    // Blink disabled holds the visible phase.
    blink_en = 1'b0;
    for (int j = 0; j < 7; j++) begin
      step();
      check($sformatf("en0_ph_%0d", j), blink_phase, 0);
    end
    check("en0_hex", hex, exp_hex(3, 8'h0C, 8'h00, 0, 1, 4));

    blink_en   = 1'b1;
    blank_mask = 8'h80;
    step();
    check("blank_d7", hex[55:49], 7'h7F);
    check("blank_all", hex, exp_hex(3, 8'h0C, 8'h80, 0, 1, 4));

    // SRCS=3, active-high, BLINK_DIV=1 instance.
    src_sel3 = 2'd3;
    step();
    check("oor_hex", hex3, 56'h0);
    check("oor_ph", blink_phase3, 0);
    step();
    check("div1_ph_1", blink_phase3, 1);
    step();
    check("div1_ph_2", blink_phase3, 0);
    src_sel3    = 2'd2;
    blink_mask3 = 8'h01;
    step();
    check("ah_ph_r", blink_phase3, 0);
    check("ah_hex_r", hex3, exp_hex(2, 8'h01, 8'h00, 0, 0, 3));
    step();
    check("ah_ph_1", blink_phase3, 1);
    check("ah_hex_1", hex3, exp_hex(2, 8'h01, 8'h00, 0, 0, 3));
    step();
    check("ah_hex_2", hex3, exp_hex(2, 8'h01, 8'h00, 1, 0, 3));
    check("ah_d0_off", hex3[6:0], 7'h00);
    blank_mask3 = 8'hFF;
    step();
    check("ah_blank", hex3, 56'h0);

    // Mid-run reset must clear outputs without a clock edge.
    step();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_hex", hex, 56'hFF_FFFF_FFFF_FFFF);
    check("mid_rst_ph", blink_phase, 0);
    check("mid_rst_hex3", hex3, 56'h0);
    check("mid_rst_ph3", blink_phase3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
